// File: rtl/tl_pkg.sv
// Shared state, grant and lamp encodings for the highway/farm-road
// intersection controller.
package tl_pkg;

  typedef enum logic [2:0] {
    HWY_GREEN   = 3'd0,
    HWY_YELLOW  = 3'd1,
    ALL_RED     = 3'd2,
    FARM_GREEN  = 3'd3,
    FARM_YELLOW = 3'd4,
    PED_WALK    = 3'd5
  } state_t;

  typedef enum logic {
    FARM = 1'b0,
    PED  = 1'b1
  } grant_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // A tie goes to whichever requester was not served last.
  function automatic grant_t pick_grant(input logic   farm_pend,
                                        input logic   ped_pend,
                                        input grant_t last_grant);
    if (farm_pend && ped_pend) return (last_grant == PED) ? FARM : PED;
    return ped_pend ? PED : FARM;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times each phase in 1 s ticks; expire flags the
// tick that ends the current phase.
module phase_timer #(
  parameter int               TMR_W     = 8,
  parameter logic [TMR_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [TMR_W-1:0] count;

  // A load on phase entry wins over a coincident tick; the count parks at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - TMR_W'(1);
    end
  end

  assign expire = tick && (count == TMR_W'(1));

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Right-of-way arbiter for the highway/farm-road intersection: sequences the
// light cycle and alternates farm and pedestrian service, with emergency pre-empt.
module intersection_phase_arbiter
  import tl_pkg::*;
#(
  parameter int MIN_GREEN_S  = 5,
  parameter int FARM_GREEN_S = 10,
  parameter int YELLOW_S     = 3,
  parameter int ALL_RED_S    = 1,
  parameter int WALK_S       = 7,
  parameter int TMR_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       farm_req,
  input  logic       ped_req,
  input  logic       emg_req,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  state_t           state, state_next;
  grant_t           grant, grant_next, last_grant;
  logic             min_done, farm_pend, ped_pend, to_hwy, to_hwy_next;
  logic             entering, expire;
  logic [TMR_W-1:0] load_val;

  function automatic logic [TMR_W-1:0] duration(input state_t s);
    case (s)
      HWY_YELLOW, FARM_YELLOW: duration = TMR_W'(YELLOW_S);
      ALL_RED:                 duration = TMR_W'(ALL_RED_S);
      FARM_GREEN:              duration = TMR_W'(FARM_GREEN_S);
      PED_WALK:                duration = TMR_W'(WALK_S);
      default:                 duration = TMR_W'(MIN_GREEN_S);
    endcase
  endfunction

  assign entering = (state_next != state);
  assign load_val = duration(state_next);

  phase_timer #(
    .TMR_W    (TMR_W),
    .RESET_VAL(TMR_W'(MIN_GREEN_S))
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (entering),
    .load_val(load_val),
    .tick    (tick),
    .expire  (expire)
  );

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    to_hwy_next = to_hwy;
    case (state)
      HWY_GREEN: begin
        if (min_done && !emg_req && (farm_pend || ped_pend)) begin
          state_next = HWY_YELLOW;
          grant_next = pick_grant(farm_pend, ped_pend, last_grant);
        end
      end
      HWY_YELLOW: begin
        if (expire) begin
          state_next  = ALL_RED;
          to_hwy_next = 1'b0;
        end
      end
      ALL_RED: begin
        if (expire) begin
          if (to_hwy || emg_req) state_next = HWY_GREEN;
          else if (grant == FARM) state_next = FARM_GREEN;
          else                    state_next = PED_WALK;
        end
      end
      FARM_GREEN: begin
        if (expire || emg_req) state_next = FARM_YELLOW;
      end
      // Farm yellow is never cut short, even under pre-empt.
      FARM_YELLOW: begin
        if (expire) begin
          state_next  = ALL_RED;
          to_hwy_next = 1'b1;
        end
      end
      PED_WALK: begin
        if (expire || emg_req) begin
          state_next  = ALL_RED;
          to_hwy_next = 1'b1;
        end
      end
      default: state_next = HWY_GREEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HWY_GREEN;
      grant      <= FARM;
      last_grant <= PED;
      min_done   <= 1'b0;
      farm_pend  <= 1'b0;
      ped_pend   <= 1'b0;
      to_hwy     <= 1'b0;
      ped_ack    <= 1'b0;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      to_hwy  <= to_hwy_next;
      ped_ack <= entering && (state_next == PED_WALK);

      if (entering && (state_next == HWY_GREEN))   min_done <= 1'b0;
      else if ((state == HWY_GREEN) && expire)     min_done <= 1'b1;

      // Clearing on service entry beats a request arriving on that same edge.
      if (entering && (state_next == FARM_GREEN))  farm_pend <= 1'b0;
      else if (farm_req && (state != FARM_GREEN) && (state != FARM_YELLOW))
        farm_pend <= 1'b1;

      if (entering && (state_next == PED_WALK))    ped_pend <= 1'b0;
      else if (ped_req && (state != PED_WALK))     ped_pend <= 1'b1;

      if (entering && (state_next == FARM_GREEN))  last_grant <= FARM;
      else if (entering && (state_next == PED_WALK)) last_grant <= PED;
    end
  end

  always_comb begin
    light_highway = LT_RED;
    light_farm    = LT_RED;
    walk          = 1'b0;
    case (state)
      HWY_GREEN:   light_highway = LT_GRN;
      HWY_YELLOW:  light_highway = LT_YEL;
      FARM_GREEN:  light_farm    = LT_GRN;
      FARM_YELLOW: light_farm    = LT_YEL;
      PED_WALK:    walk          = 1'b1;
      default:     ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Scoreboard bench for intersection_phase_arbiter: a phase-table reference model
// predicts every cycle's lamps and a monitor compares them against the DUT.
module tb_intersection_phase_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       farm_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       emg_req = 1'b0;
  logic [2:0] light_highway, light_farm, phase;
  logic       walk, ped_ack;

  intersection_phase_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .farm_req     (farm_req),
    .ped_req      (ped_req),
    .emg_req      (emg_req),
    .light_highway(light_highway),
    .light_farm   (light_farm),
    .walk         (walk),
    .ped_ack      (ped_ack),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] hw;
    logic [2:0] fm;
    logic       walk;
    logic       ack;
    logic [2:0] ph;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Reference model: phase number 0..5 plus ticks left, lamps from tables.
  int         dur_tbl[6] = '{5, 3, 1, 10, 3, 7};
  logic [2:0] hw_tbl[6]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] fm_tbl[6]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int m_phase, m_left;
  bit m_min, m_fw, m_pw, m_last_ped, m_serve_ped, m_ret, m_ack;

  function automatic obs_t model_obs();
    obs_t o;
    o.hw   = hw_tbl[m_phase];
    o.fm   = fm_tbl[m_phase];
    o.walk = (m_phase == 5);
    o.ack  = m_ack;
    o.ph   = 3'(m_phase);
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = dur_tbl[0]; m_min = 0; m_fw = 0; m_pw = 0;
    m_last_ped = 1; m_serve_ped = 0; m_ret = 0; m_ack = 0;
  endtask

  task automatic model_edge(input bit t, input bit fr, input bit pr, input bit er);
    int n_phase, n_left;
    bit done, n_min, n_fw, n_pw, n_last, n_serve, n_ret;
    done = t && (m_left == 1);
    n_phase = m_phase; n_left = (t && m_left > 0) ? m_left - 1 : m_left;
    n_min = m_min; n_fw = m_fw; n_pw = m_pw; n_last = m_last_ped;
    n_serve = m_serve_ped; n_ret = m_ret;
    case (m_phase)
      0: begin
        if (done) n_min = 1;
        if (m_min && !er && (m_fw || m_pw)) begin
          n_phase = 1;
          n_serve = (m_fw && m_pw) ? !m_last_ped : m_pw;
        end
      end
      1: if (done) begin n_phase = 2; n_ret = 0; end
      2: if (done) n_phase = (m_ret || er) ? 0 : (m_serve_ped ? 5 : 3);
      3: if (done || er) n_phase = 4;
      4: if (done) begin n_phase = 2; n_ret = 1; end
      5: if (done || er) begin n_phase = 2; n_ret = 1; end
      default: n_phase = 0;
    endcase
    if (fr && m_phase != 3 && m_phase != 4) n_fw = 1;
    if (pr && m_phase != 5) n_pw = 1;
    m_ack = 0;
    if (n_phase != m_phase) begin
      n_left = dur_tbl[n_phase];
      if (n_phase == 0) n_min = 0;
      if (n_phase == 3) begin n_fw = 0; n_last = 0; end
      if (n_phase == 5) begin n_pw = 0; n_last = 1; m_ack = 1; end
    end
    m_phase = n_phase; m_left = n_left; m_min = n_min; m_fw = n_fw; m_pw = n_pw;
    m_last_ped = n_last; m_serve_ped = n_serve; m_ret = n_ret;
  endtask

  task automatic checkOutput(input string tag, input obs_t e);
    obs_t a;
    a.hw = light_highway; a.fm = light_farm; a.walk = walk; a.ack = ped_ack; a.ph = phase;
    n_checks++;
    if (a === e) n_pass++;
    else $display("[TB] FAIL %s t=%0t: got hw=%b fm=%b walk=%b ack=%b phase=%0d, expected hw=%b fm=%b walk=%b ack=%b phase=%0d",
                  tag, $time, a.hw, a.fm, a.walk, a.ack, a.ph, e.hw, e.fm, e.walk, e.ack, e.ph);
  endtask

  task automatic applyStimulus(input int cycles, input bit fr, input bit pr, input bit er);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      tick = (cyc % 4 == 3);
      cyc++;
      farm_req = fr; ped_req = pr; emg_req = er;
      model_edge(tick, fr, pr, er);
      exp_q.push_back(model_obs());
    end
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; farm_req = 1'b0; ped_req = 1'b0; emg_req = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset", model_obs());
    exp_q.push_back(model_obs());
    for (int i = 1; i < cycles; i++) begin
      @(negedge clk);
      exp_q.push_back(model_obs());
    end
  endtask

  task automatic waitModelPhase(input int ph, input int limit);
    int k = 0;
    while (m_phase != ph && k < limit) begin
      applyStimulus(1, 0, 0, 0);
      k++;
    end
    if (m_phase != ph) begin
      n_checks++;
      $display("[TB] FAIL reach_phase: got model phase %0d, required %0d within %0d cycles", m_phase, ph, limit);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) checkOutput("scoreboard", exp_q.pop_front());
  end

  initial begin
    bit fr, pr, er;
    int emg_cnt;
    fr = 0; emg_cnt = 0;

    applyReset(3);
    $display("[TB] idle highway green");
    applyStimulus(80, 0, 0, 0);

    $display("[TB] farm request held");
    applyStimulus(100, 1, 0, 0);
    applyStimulus(40, 0, 0, 0);

    $display("[TB] single pedestrian press, second press during walk");
    applyStimulus(1, 0, 1, 0);
    waitModelPhase(5, 200);
    applyStimulus(8, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(60, 0, 0, 0);

    $display("[TB] farm/ped ties alternate");
    applyStimulus(4, 1, 1, 0);
    applyStimulus(250, 0, 0, 0);
    applyStimulus(4, 1, 1, 0);
    applyStimulus(250, 0, 0, 0);

    $display("[TB] emergency during farm green");
    applyStimulus(1, 1, 0, 0);
    waitModelPhase(3, 300);
    applyStimulus(8, 0, 0, 0);
    applyStimulus(1, 0, 1, 1);
    applyStimulus(80, 0, 0, 1);
    applyStimulus(100, 0, 0, 0);

    $display("[TB] reset during walk");
    applyStimulus(1, 0, 1, 0);
    waitModelPhase(5, 300);
    applyStimulus(6, 0, 0, 0);
    applyReset(2);
    applyStimulus(100, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) fr = !fr;
      pr = ($urandom_range(0, 49) == 0);
      if (emg_cnt == 0 && $urandom_range(0, 299) == 0) emg_cnt = $urandom_range(4, 80);
      er = (emg_cnt != 0);
      if (emg_cnt != 0) emg_cnt--;
      applyStimulus(1, fr, pr, er);
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("[TB] FAIL drain: got %0d unchecked entries, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
